// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU pipeline constants: register state encoding and
//                default datapath widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int C_DATA_W_DEF = 32;
    localparam int C_RN_W_DEF   = 5;

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_full  = 2'd1;
    localparam logic [1:0] c_st_skid  = 2'd2;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/exe_mem_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : exe_mem_pipe_reg
//  Description : EXE->MEM pipeline register with valid/ready handshake, a skid
//                entry so exe_ready never depends on mem_ready, flush, and a
//                saturating stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module exe_mem_pipe_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = C_DATA_W_DEF,
    parameter int RN_W   = C_RN_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              flush,
    input  logic              exe_valid,
    output logic              exe_ready,
    input  logic [DATA_W-1:0] exe_alu_result,
    input  logic [DATA_W-1:0] exe_rb,
    input  logic              exe_wmem,
    input  logic              exe_m2reg,
    input  logic              exe_wreg,
    input  logic [RN_W-1:0]   exe_rn,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_rb,
    output logic [RN_W-1:0]   mem_rn,
    output logic              mem_wmem,
    output logic              mem_m2reg,
    output logic              mem_wreg,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Payload layout {alu_result, rb, rn, wmem, m2reg, wreg}; control in [2:0]
    localparam int c_pay_w = 2 * DATA_W + RN_W + 3;

    logic [1:0]         r_state;
    logic [c_pay_w-1:0] r_main;
    logic [c_pay_w-1:0] r_skid;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [c_pay_w-1:0] w_in_pay;
    logic               w_in;
    logic               w_out;

    assign w_in_pay = {exe_alu_result, exe_rb, exe_rn, exe_wmem, exe_m2reg, exe_wreg};

    // Both flags decode registered state only, so no mem_ready->exe_ready path
    assign exe_ready = (r_state != c_st_skid);
    assign mem_valid = (r_state != c_st_empty);

    assign w_in  = exe_valid & exe_ready;
    assign w_out = mem_valid & mem_ready;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= c_st_empty;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state     <= c_st_empty;
            r_main[2:0] <= 3'b000;
            r_skid[2:0] <= 3'b000;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (w_in) begin
                        r_main  <= w_in_pay;
                        r_state <= c_st_full;
                    end
                end
                c_st_full: begin
                    if (w_in && w_out) begin
                        r_main <= w_in_pay;
                    end else if (w_in) begin
                        r_skid  <= w_in_pay;
                        r_state <= c_st_skid;
                    end else if (w_out) begin
                        r_state <= c_st_empty;
                    end
                end
                c_st_skid: begin
                    if (w_out) begin
                        r_main  <= r_skid;
                        r_state <= c_st_full;
                    end
                end
                default: r_state <= c_st_empty;
            endcase
        end
    end

    // Counts through flush cycles too; only reset clears it
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_stall_cnt <= '0;
        end else if (mem_valid && !mem_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign mem_alu_result = r_main[c_pay_w-1 -: DATA_W];
    assign mem_rb         = r_main[c_pay_w-1-DATA_W -: DATA_W];
    assign mem_rn         = r_main[RN_W+2:3];
    assign mem_wmem       = r_main[2] & mem_valid;
    assign mem_m2reg      = r_main[1] & mem_valid;
    assign mem_wreg       = r_main[0] & mem_valid;
    assign stall_cnt      = r_stall_cnt;

endmodule : exe_mem_pipe_reg
`default_nettype wire
